// File: rtl/app_rd_to_fifo.sv
// DDR read dispatcher: pops read addresses, issues READ commands with credit
// flow control, and packs two 64-bit return beats into one 128-bit FIFO push.
module app_rd_to_fifo #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             has_rd_adx,
  input  logic [26:0]      address_in,
  output logic             get_rd_adx,
  output logic             app_en,
  output logic [2:0]       app_cmd,
  output logic [26:0]      address_out,
  input  logic             app_rdy,
  input  logic [63:0]      app_rd_data,
  input  logic             app_rd_data_valid,
  input  logic             app_rd_data_end,
  output logic [127:0]     read_data_out,
  output logic             put_rd_data,
  output logic [CNT_W-1:0] outstanding,
  output logic             protocol_err
);

  localparam logic S_IDLE  = 1'b0;
  localparam logic S_ISSUE = 1'b1;
  localparam logic B_BEAT0 = 1'b0;
  localparam logic B_BEAT1 = 1'b1;

  localparam logic [CNT_W:0] MAX_C = (CNT_W+1)'(MAX_OUTSTANDING);

  logic             r_state;
  logic             r_beat;
  logic [26:0]      r_addr;
  logic [63:0]      r_low;
  logic [127:0]     r_data;
  logic             r_put;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic             w_accept;
  logic             w_complete;
  logic [CNT_W:0]   w_cnt_nxt;
  logic             w_cnt_err;
  logic             w_credit_ok;
  logic             w_get;
  logic             w_beat_err;

  assign w_accept   = (r_state == S_ISSUE) && app_rdy;
  assign w_complete = r_put;

  // Completing with nothing in flight is a protocol fault; clamp at zero.
  always_comb begin
    w_cnt_nxt = {1'b0, r_cnt};
    w_cnt_err = 1'b0;
    case ({w_accept, w_complete})
      2'b10: w_cnt_nxt = {1'b0, r_cnt} + 1'b1;
      2'b01: begin
        if (r_cnt == '0) w_cnt_err = 1'b1;
        else w_cnt_nxt = {1'b0, r_cnt} - 1'b1;
      end
      2'b11: w_cnt_err = (r_cnt == '0);
      default: ;
    endcase
  end

  assign w_credit_ok = (w_cnt_nxt < MAX_C);

  always_comb begin
    w_get = 1'b0;
    case (r_state)
      S_IDLE:  w_get = has_rd_adx && w_credit_ok;
      S_ISSUE: w_get = w_accept && has_rd_adx && w_credit_ok;
      default: w_get = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_addr  <= 27'h7FFFFFF;
    end else if (w_get) begin
      r_state <= S_ISSUE;
      r_addr  <= {address_in[26:3], 3'b000};
    end else if (w_accept) begin
      r_state <= S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_cnt <= '0;
    else r_cnt <= w_cnt_nxt[CNT_W-1:0];
  end

  assign w_beat_err = app_rd_data_valid &&
    ((r_beat == B_BEAT0) == app_rd_data_end);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_beat <= B_BEAT0;
      r_low  <= '0;
      r_data <= '0;
      r_put  <= 1'b0;
    end else begin
      r_put <= 1'b0;
      if (app_rd_data_valid) begin
        unique case (1'b1)
          (r_beat == B_BEAT0) && !app_rd_data_end: begin
            r_low  <= app_rd_data;
            r_beat <= B_BEAT1;
          end
          (r_beat == B_BEAT1) && app_rd_data_end: begin
            r_data <= {app_rd_data, r_low};
            r_put  <= 1'b1;
            r_beat <= B_BEAT0;
          end
          (r_beat == B_BEAT1) && !app_rd_data_end: r_low <= app_rd_data;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_err <= 1'b0;
    else if (w_cnt_err || w_beat_err) r_err <= 1'b1;
  end

  assign get_rd_adx    = w_get;
  assign app_en        = (r_state == S_ISSUE);
  assign app_cmd       = 3'b001;
  assign address_out   = r_addr;
  assign read_data_out = r_data;
  assign put_rd_data   = r_put;
  assign outstanding   = r_cnt;
  assign protocol_err  = r_err;

endmodule

// File: tb/tb_app_rd_to_fifo.sv
// Scoreboard bench for app_rd_to_fifo: expected commands and data words are
// queued at stimulus time and checked by a monitor on the falling edge.
module tb_app_rd_to_fifo;

  logic         clk = 1'b0;
  logic         resetn;
  logic         has_rd_adx;
  logic [26:0]  address_in;
  logic         get_rd_adx;
  logic         app_en;
  logic [2:0]   app_cmd;
  logic [26:0]  address_out;
  logic         app_rdy;
  logic [63:0]  app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic [127:0] read_data_out;
  logic         put_rd_data;
  logic [3:0]   outstanding;
  logic         protocol_err;

  always #5 clk = ~clk;

  app_rd_to_fifo #(.MAX_OUTSTANDING(8), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .has_rd_adx(has_rd_adx), .address_in(address_in),
    .get_rd_adx(get_rd_adx), .app_en(app_en), .app_cmd(app_cmd),
    .address_out(address_out), .app_rdy(app_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end), .read_data_out(read_data_out),
    .put_rd_data(put_rd_data), .outstanding(outstanding),
    .protocol_err(protocol_err)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [26:0]  exp_cmd[$];
  logic [127:0] exp_dat[$];

  // first-word fall-through model of ddr_fifo
  logic [26:0] fmem [32];
  int wp = 0;
  int rp = 0;
  assign has_rd_adx = (wp != rp);
  assign address_in = fmem[rp[4:0]];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) rp <= wp;
    else if (get_rd_adx) rp <= rp + 1;
  end

  int n_acc = 0, n_pop = 0, n_put = 0, n_en = 0;
  int run = 0, max_run = 0, max_out = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got unexpected event expected none", nm);
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (int'(outstanding) > max_out) max_out = int'(outstanding);
      if (get_rd_adx) n_pop++;
      if (app_en) begin
        n_en++;
        chk("app_cmd", 128'(app_cmd), 128'(3'b001));
        if (exp_cmd.size() == 0) fail_now("cmd_unexpected");
        else begin
          chk("cmd_addr", 128'(address_out), 128'(exp_cmd[0]));
          if (app_rdy) begin
            void'(exp_cmd.pop_front());
            n_acc++;
            run++;
            if (run > max_run) max_run = run;
          end else run = 0;
        end
      end else run = 0;
      if (put_rd_data) begin
        n_put++;
        if (exp_dat.size() == 0) fail_now("data_unexpected");
        else chk("rd_data", read_data_out, exp_dat.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_addr(input logic [26:0] a);
    fmem[wp[4:0]] = a;
    wp++;
    exp_cmd.push_back({a[26:3], 3'b000});
  endtask

  task automatic send_burst(input logic [63:0] b0, input logic [63:0] b1);
    app_rd_data_valid = 1'b1;
    app_rd_data_end   = 1'b0;
    app_rd_data       = b0;
    tick(1);
    app_rd_data_end = 1'b1;
    app_rd_data     = b1;
    exp_dat.push_back({b1, b0});
    tick(1);
    app_rd_data_valid = 1'b0;
    app_rd_data_end   = 1'b0;
    @(negedge clk);
    chk("put_latency", 128'(put_rd_data), 128'(1));
  endtask

  task automatic beat(input logic [63:0] d, input logic e);
    app_rd_data_valid = 1'b1;
    app_rd_data_end   = e;
    app_rd_data       = d;
    tick(1);
    app_rd_data_valid = 1'b0;
    app_rd_data_end   = 1'b0;
  endtask

  task automatic chk_reset_state;
    chk("rst_app_en", 128'(app_en), 128'(0));
    chk("rst_get", 128'(get_rd_adx), 128'(0));
    chk("rst_put", 128'(put_rd_data), 128'(0));
    chk("rst_outstanding", 128'(outstanding), 128'(0));
    chk("rst_perr", 128'(protocol_err), 128'(0));
    chk("rst_addr", 128'(address_out), 128'(27'h7FFFFFF));
    chk("rst_data", read_data_out, 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int a0, p0, u0;

  initial begin
    resetn = 1'b0;
    app_rdy = 1'b0;
    app_rd_data = '0;
    app_rd_data_valid = 1'b0;
    app_rd_data_end = 1'b0;
    tick(3);
    resetn = 1'b1;
    @(negedge clk);
    chk_reset_state();

    // single read
    app_rdy = 1'b1;
    a0 = n_acc;
    tick(1);
    push_addr(27'h00000AB);
    u0 = n_en;
    tick(3);
    chk("t1_accepts", 128'(n_acc - a0), 128'(1));
    chk("t1_en_cycles", 128'(n_en - u0), 128'(1));
    chk("t1_outstanding1", 128'(outstanding), 128'(1));
    send_burst(64'h1111, 64'h2222);
    tick(2);
    chk("t1_outstanding0", 128'(outstanding), 128'(0));

    // stalled then back-to-back
    app_rdy = 1'b0;
    a0 = n_acc;
    p0 = n_pop;
    max_run = 0;
    for (int i = 0; i < 5; i++) push_addr(27'h1000 + 27'(i * 9));
    tick(4);
    chk("t2_stalled_en", 128'(app_en), 128'(1));
    chk("t2_no_accept", 128'(n_acc - a0), 128'(0));
    app_rdy = 1'b1;
    tick(8);
    chk("t2_accepts", 128'(n_acc - a0), 128'(5));
    chk("t2_pops", 128'(n_pop - p0), 128'(5));
    chk("t2_b2b_run", 128'(max_run), 128'(5));
    chk("t2_outstanding", 128'(outstanding), 128'(5));
    for (int i = 0; i < 5; i++)
      send_burst(64'hA000 + 64'(i), 64'hB000 + 64'(i));
    tick(2);
    chk("t2_outstanding0", 128'(outstanding), 128'(0));

    // credit limit
    a0 = n_acc;
    max_out = 0;
    for (int i = 0; i < 12; i++) push_addr(27'h200000 + 27'(i * 8));
    tick(20);
    chk("t3_accepts8", 128'(n_acc - a0), 128'(8));
    chk("t3_outstanding8", 128'(outstanding), 128'(8));
    chk("t3_get_blocked", 128'(get_rd_adx), 128'(0));
    send_burst(64'hC0, 64'hC1);
    chk("t4_pop_on_complete", 128'(get_rd_adx), 128'(1));
    tick(3);
    chk("t3_accepts9", 128'(n_acc - a0), 128'(9));
    chk("t4_outstanding8", 128'(outstanding), 128'(8));
    for (int i = 0; i < 11; i++)
      send_burst(64'hD00 + 64'(i), 64'hE00 + 64'(i));
    tick(4);
    chk("t3_accepts12", 128'(n_acc - a0), 128'(12));
    chk("t4_max_out", 128'(max_out), 128'(8));
    chk("t3_outstanding0", 128'(outstanding), 128'(0));
    chk("t3_cmd_drained", 128'(exp_cmd.size()), 128'(0));
    chk("t3_perr_clean", 128'(protocol_err), 128'(0));

    // beat protocol violations
    u0 = n_put;
    beat(64'hBAD0, 1'b1);
    @(negedge clk);
    chk("t5_perr_set", 128'(protocol_err), 128'(1));
    chk("t5_no_put", 128'(put_rd_data), 128'(0));
    beat(64'hF1, 1'b0);
    beat(64'hF2, 1'b0);
    exp_dat.push_back({64'hF3, 64'hF2});
    beat(64'hF3, 1'b1);
    tick(3);
    chk("t5_put_count", 128'(n_put - u0), 128'(1));
    chk("t5_perr_sticky", 128'(protocol_err), 128'(1));

    // reset mid-operation
    app_rdy = 1'b1;
    push_addr(27'h0300010);
    tick(4);
    chk("t6_outstanding1", 128'(outstanding), 128'(1));
    app_rdy = 1'b0;
    push_addr(27'h0300020);
    beat(64'hDEAD, 1'b0);
    tick(1);
    chk("t6_pre_issue", 128'(app_en), 128'(1));
    resetn = 1'b0;
    #1;
    exp_cmd.delete();
    exp_dat.delete();
    chk("t6_async_en", 128'(app_en), 128'(0));
    chk("t6_async_cnt", 128'(outstanding), 128'(0));
    tick(2);
    resetn = 1'b1;
    @(negedge clk);
    chk_reset_state();
    app_rdy = 1'b1;
    tick(1);
    push_addr(27'h0400007);
    tick(4);
    chk("t6_outstanding1b", 128'(outstanding), 128'(1));
    send_burst(64'h5555, 64'h6666);
    tick(2);
    chk("t6_perr_clean", 128'(protocol_err), 128'(0));
    chk("t6_outstanding0", 128'(outstanding), 128'(0));
    chk("end_cmd_empty", 128'(exp_cmd.size()), 128'(0));
    chk("end_dat_empty", 128'(exp_dat.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
